// File: rtl/mul_unit_iter_if.sv
// Request/response bundle of the iterative multiplier: valid/ready request with
// tag and operands, single-cycle response pulse with tag and result.
interface mul_unit_iter_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 4
);
    logic             kill_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [2:0]       func3_i;
    logic             int_32_i;
    logic [TAG_W-1:0] tag_i;
    logic [XLEN-1:0]  src1_i;
    logic [XLEN-1:0]  src2_i;
    logic             resp_valid_o;
    logic [TAG_W-1:0] resp_tag_o;
    logic [XLEN-1:0]  result_o;
    logic             busy_o;

    modport master (
        output kill_i, req_valid_i, func3_i, int_32_i, tag_i, src1_i, src2_i,
        input  req_ready_o, resp_valid_o, resp_tag_o, result_o, busy_o
    );

    modport slave (
        input  kill_i, req_valid_i, func3_i, int_32_i, tag_i, src1_i, src2_i,
        output req_ready_o, resp_valid_o, resp_tag_o, result_o, busy_o
    );
endinterface

// File: rtl/mul_unit_iter.sv
// Iterative RV M-extension multiplier: one CHUNK-bit slice of |src2| per cycle.
// Define MUL_WORD_OP_EN to build the MULW path (32/CHUNK iterations, XLEN = 64 only).
module mul_unit_iter #(
    parameter int XLEN  = 64,
    parameter int CHUNK = 16,
    parameter int TAG_W = 4
) (
    input logic            clk_i,
    input logic            rstn_i,
    mul_unit_iter_if.slave bus
);
    localparam int N_FULL = XLEN / CHUNK;
    localparam int CW     = $clog2(N_FULL + 1);
    localparam int SHW    = $clog2(2 * XLEN);

    typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

    typedef struct packed {
        logic             neg;
        logic [2:0]       func3;
`ifdef MUL_WORD_OP_EN
        logic             word;
`endif
        logic [TAG_W-1:0] tag;
    } op_t;

    state_t            state;
    op_t               op;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [2*XLEN-1:0] acc;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   result;
    logic [TAG_W-1:0]  resp_tag;

    logic              ready, accept, word_in, s1, s2, last;
    logic [XLEN-1:0]   a_in, b_in, a_abs, b_abs;
    logic [SHW-1:0]    shamt;
    logic [CHUNK-1:0]  chunk;
    logic [XLEN+CHUNK-1:0] pp;
    logic [2*XLEN-1:0] acc_nxt, prod;
    logic [XLEN-1:0]   res_nxt;
    logic [CW-1:0]     last_cnt;

    assign ready  = (state == IDLE) || (state == DONE);
    assign accept = bus.req_valid_i && ready && !bus.kill_i;

`ifdef MUL_WORD_OP_EN
    assign word_in  = (XLEN == 64) && bus.int_32_i;
    assign last_cnt = op.word ? CW'(32 / CHUNK - 1) : CW'(N_FULL - 1);
`else
    assign word_in  = 1'b0;
    assign last_cnt = CW'(N_FULL - 1);
`endif

    // Word ops work on the sign-extended low halves, so their magnitudes fit in 32 bits.
    assign a_in  = word_in ? XLEN'($signed(bus.src1_i[31:0])) : bus.src1_i;
    assign b_in  = word_in ? XLEN'($signed(bus.src2_i[31:0])) : bus.src2_i;
    assign s1    = (bus.func3_i != 3'b011) && a_in[XLEN-1];
    assign s2    = !bus.func3_i[1] && b_in[XLEN-1];
    assign a_abs = s1 ? -a_in : a_in;
    assign b_abs = s2 ? -b_in : b_in;

    // CHUNK is a power of two, so cnt*CHUNK is a plain shift.
    assign shamt   = SHW'(cnt) << $clog2(CHUNK);
    assign chunk   = CHUNK'(b_mag >> shamt);
    assign pp      = {{CHUNK{1'b0}}, a_mag} * {{XLEN{1'b0}}, chunk};
    assign acc_nxt = acc + ((2*XLEN)'(pp) << shamt);
    assign prod    = op.neg ? -acc_nxt : acc_nxt;
    assign last    = (cnt == last_cnt);

    always_comb begin
        res_nxt = '0;
`ifdef MUL_WORD_OP_EN
        if (op.word) begin
            if (op.func3 == 3'b000) res_nxt = XLEN'($signed(prod[31:0]));
        end else
`endif
        begin
            case (op.func3)
                3'b000:                res_nxt = prod[XLEN-1:0];
                3'b001, 3'b010, 3'b011: res_nxt = prod[2*XLEN-1:XLEN];
                default:               res_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= IDLE;
            op       <= '0;
            a_mag    <= '0;
            b_mag    <= '0;
            acc      <= '0;
            cnt      <= '0;
            result   <= '0;
            resp_tag <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op.neg   <= s1 ^ s2;
                        op.func3 <= bus.func3_i;
`ifdef MUL_WORD_OP_EN
                        op.word  <= word_in;
`endif
                        op.tag   <= bus.tag_i;
                        a_mag    <= a_abs;
                        b_mag    <= b_abs;
                        acc      <= '0;
                        cnt      <= '0;
                        state    <= MULT;
                    end else begin
                        state    <= IDLE;
                    end
                end
                MULT: begin
                    if (bus.kill_i) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_nxt;
                        cnt <= cnt + CW'(1);
                        if (last) begin
                            result   <= res_nxt;
                            resp_tag <= op.tag;
                            state    <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o  = ready;
    assign bus.busy_o       = (state == MULT);
    assign bus.resp_valid_o = (state == DONE) && !bus.kill_i;
    assign bus.result_o     = result;
    assign bus.resp_tag_o   = resp_tag;
endmodule
